// File: rtl/misr_test_sequencer.sv
// Hardware BIST initiator for the MISR peripheral. It programs the coefficients, runs the MISR for a fixed
// number of cycles, polls DONE, reads SIGNATURE and compares it with the golden value.
module misr_test_sequencer #(
  parameter int                  NBIT_DATA  = 32,
  parameter int                  NBIT_ADDR  = 64,
  parameter int                  NBIT_REGS  = 32,
  parameter logic [NBIT_ADDR-1:0] START_ADDR = NBIT_ADDR'(2**25),
  parameter int                  CNT_W      = 16,
  parameter int                  POLL_MAX   = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [NBIT_REGS-1:0] coeff_i,
  input  logic [NBIT_REGS-1:0] golden_i,
  input  logic [CNT_W-1:0]     num_cycles_i,
  output logic                 re_o,
  output logic                 we_o,
  output logic [NBIT_ADDR-1:0] addr_o,
  output logic [NBIT_DATA-1:0] data_csr_o,
  input  logic [NBIT_DATA-1:0] data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic                 timeout_o,
  output logic [NBIT_REGS-1:0] signature_o
);

  localparam logic [NBIT_ADDR-1:0] STRIDE     = NBIT_ADDR'(NBIT_REGS / 8);
  localparam logic [NBIT_ADDR-1:0] ADDR_CTRL  = START_ADDR;
  localparam logic [NBIT_ADDR-1:0] ADDR_COEFF = START_ADDR + STRIDE;
  localparam logic [NBIT_ADDR-1:0] ADDR_SIG   = START_ADDR + STRIDE + STRIDE;
  localparam logic [NBIT_ADDR-1:0] ADDR_DONE  = START_ADDR + STRIDE + STRIDE + STRIDE;

  localparam int              PW        = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);
  localparam logic [PW-1:0]   POLL_LAST = PW'(POLL_MAX - 1);
  localparam logic [PW-1:0]   POLL_SAT  = PW'(POLL_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_COEFF, S_WR_RST, S_WR_EN, S_RUN,
    S_WR_CLOSE, S_POLL, S_RD_SIG, S_WR_IDLE, S_FINISH
  } state_t;

  state_t               state_q, state_d;
  logic [NBIT_REGS-1:0] coeff_q, coeff_d;
  logic [NBIT_REGS-1:0] golden_q, golden_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [CNT_W-1:0]     run_cnt_q, run_cnt_d;
  logic [PW-1:0]        poll_cnt_q, poll_cnt_d;
  logic                 re_q, re_d;
  logic                 we_q, we_d;
  logic [NBIT_ADDR-1:0] addr_q, addr_d;
  logic [NBIT_DATA-1:0] wdata_q, wdata_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic [NBIT_REGS-1:0] sig_q, sig_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      coeff_q    <= '0;
      golden_q   <= '0;
      num_q      <= '0;
      run_cnt_q  <= '0;
      poll_cnt_q <= '0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
      sig_q      <= '0;
    end else begin
      state_q    <= state_d;
      coeff_q    <= coeff_d;
      golden_q   <= golden_d;
      num_q      <= num_d;
      run_cnt_q  <= run_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      re_q       <= re_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
      sig_q      <= sig_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    coeff_d    = coeff_q;
    golden_d   = golden_q;
    num_d      = num_q;
    run_cnt_d  = run_cnt_q;
    poll_cnt_d = poll_cnt_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    sig_d      = sig_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          coeff_d   = coeff_i;
          golden_d  = golden_i;
          num_d     = num_cycles_i;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          sig_d     = '0;
          state_d   = S_WR_COEFF;
        end
      end
      S_WR_COEFF: state_d = S_WR_RST;
      S_WR_RST:   state_d = S_WR_EN;
      S_WR_EN: begin
        run_cnt_d = num_q;
        state_d   = (num_q == '0) ? S_WR_CLOSE : S_RUN;
      end
      S_RUN: begin
        if (run_cnt_q != '0) run_cnt_d = run_cnt_q - CNT_W'(1);
        if (run_cnt_q <= CNT_W'(1)) state_d = S_WR_CLOSE;
      end
      S_WR_CLOSE: begin
        poll_cnt_d = '0;
        state_d    = S_POLL;
      end
      S_POLL: begin
        if (data_i[0]) begin
          state_d = S_RD_SIG;
        end else begin
          if (poll_cnt_q != POLL_SAT) poll_cnt_d = poll_cnt_q + PW'(1);
          if (poll_cnt_q >= POLL_LAST) begin
            timeout_d = 1'b1;
            state_d   = S_WR_IDLE;
          end
        end
      end
      S_RD_SIG: begin
        sig_d   = data_i[NBIT_REGS-1:0];
        pass_d  = (data_i[NBIT_REGS-1:0] == golden_q);
        state_d = S_WR_IDLE;
      end
      S_WR_IDLE: state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so the registered access lines up with the state it belongs to.
  always_comb begin
    re_d    = 1'b0;
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    case (state_d)
      S_WR_COEFF: begin we_d = 1'b1; addr_d = ADDR_COEFF; wdata_d = NBIT_DATA'(coeff_d); end
      S_WR_RST:   begin we_d = 1'b1; addr_d = ADDR_CTRL;  wdata_d = NBIT_DATA'(3'h0);   end
      S_WR_EN:    begin we_d = 1'b1; addr_d = ADDR_CTRL;  wdata_d = NBIT_DATA'(3'h3);   end
      S_WR_CLOSE: begin we_d = 1'b1; addr_d = ADDR_CTRL;  wdata_d = NBIT_DATA'(3'h6);   end
      S_POLL:     begin re_d = 1'b1; addr_d = ADDR_DONE;                                end
      S_RD_SIG:   begin re_d = 1'b1; addr_d = ADDR_SIG;                                 end
      S_WR_IDLE:  begin we_d = 1'b1; addr_d = ADDR_CTRL;  wdata_d = NBIT_DATA'(3'h2);   end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
  end

  assign re_o        = re_q;
  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign data_csr_o  = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign signature_o = sig_q;

endmodule

// File: tb/tb_misr_test_sequencer.sv
// Bench for misr_test_sequencer: a behavioural MISR peripheral answers the bus, and each run's bus trace,
// latency and results are compared with what the sequence rules predict.
module tb_misr_test_sequencer;

  localparam int          P       = 4;
  localparam logic [63:0] A_CTRL  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_COEFF = A_CTRL + 64'd4;
  localparam logic [63:0] A_SIG   = A_CTRL + 64'd8;
  localparam logic [63:0] A_DONE  = A_CTRL + 64'd12;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [31:0] coeff_i, golden_i;
  logic [15:0] num_cycles_i;
  logic        re_o, we_o;
  logic [63:0] addr_o;
  logic [31:0] data_csr_o;
  logic [31:0] data_i;
  logic        busy_o, done_o, pass_o, timeout_o;
  logic [31:0] signature_o;

  always #5 clk_i = ~clk_i;

  misr_test_sequencer #(.POLL_MAX(P)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .coeff_i(coeff_i), .golden_i(golden_i),
    .num_cycles_i(num_cycles_i), .re_o(re_o), .we_o(we_o), .addr_o(addr_o), .data_csr_o(data_csr_o),
    .data_i(data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .timeout_o(timeout_o),
    .signature_o(signature_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signature after n enabled compaction cycles, MISR fed with a fixed per-cycle stimulus word.
  function automatic logic [31:0] misr_ref(input logic [31:0] c, input int n);
    logic [31:0] s;
    logic [31:0] w;
    s = '0;
    for (int i = 0; i < n; i++) begin
      w = 32'(i + 1) * 32'h9E37_79B9;
      s = (s << 1) ^ (s[31] ? c : 32'h0) ^ w;
    end
    return s;
  endfunction

  // Peripheral model
  logic [31:0] r_coeff;
  logic [2:0]  r_ctrl;
  int          r_en, r_reads;
  int          fail_n = 0;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_coeff <= '0; r_ctrl <= '0; r_en <= 0; r_reads <= 0;
    end else begin
      if (!r_ctrl[1]) r_en <= 0;
      else if (r_ctrl[0]) r_en <= r_en + 1;
      if (we_o && addr_o == A_COEFF) begin r_coeff <= data_csr_o; r_reads <= 0; end
      if (we_o && addr_o == A_CTRL) r_ctrl <= data_csr_o[2:0];
      if (re_o && addr_o == A_DONE) r_reads <= r_reads + 1;
    end
  end

  always_comb begin
    data_i = '0;
    if (re_o && addr_o == A_DONE) data_i = 32'hDEAD_BEE0 | ((r_reads >= fail_n) ? 32'h1 : 32'h0);
    else if (re_o && addr_o == A_SIG) data_i = misr_ref(r_coeff, r_en);
  end

  typedef struct {int kind; logic [63:0] addr; logic [31:0] data;} acc_t;
  acc_t exp_q[$];
  acc_t act_q[$];

  function automatic acc_t mk(input int k, input logic [63:0] a, input logic [31:0] d);
    acc_t x;
    x.kind = k; x.addr = a; x.data = d;
    return x;
  endfunction

  // One complete run started at a negedge; leaves the bench at a negedge one cycle after done_o.
  task automatic run_one(input string tag, input logic [31:0] coeff, input logic [31:0] golden,
                         input int n, input int fn, input bit pulse_mid,
                         output bit p, output bit t, output int lat);
    logic [31:0] ref_sig;
    logic [31:0] s;
    bit          to, exp_pass;
    int          bad, first_bad;
    ref_sig  = misr_ref(coeff, n + 1);
    to       = (fn >= P);
    exp_pass = !to && (golden == ref_sig);
    exp_q.delete();
    exp_q.push_back(mk(2, A_COEFF, coeff));
    exp_q.push_back(mk(2, A_CTRL, 32'h0));
    exp_q.push_back(mk(2, A_CTRL, 32'h3));
    for (int i = 0; i < n; i++) exp_q.push_back(mk(0, 64'h0, 32'h0));
    exp_q.push_back(mk(2, A_CTRL, 32'h6));
    if (!to) begin
      for (int i = 0; i <= fn; i++) exp_q.push_back(mk(1, A_DONE, 32'h0));
      exp_q.push_back(mk(1, A_SIG, 32'h0));
    end else begin
      for (int i = 0; i < P; i++) exp_q.push_back(mk(1, A_DONE, 32'h0));
    end
    exp_q.push_back(mk(2, A_CTRL, 32'h2));
    exp_q.push_back(mk(0, 64'h0, 32'h0));

    fail_n = fn;
    coeff_i = coeff; golden_i = golden; num_cycles_i = 16'(n); start_i = 1'b1;
    act_q.delete();
    lat = -1; bad = 0; p = 1'b0; t = 1'b0; s = '0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk_i);
      if (re_o && we_o) bad++;
      if (!re_o && !we_o && (addr_o != 64'h0 || data_csr_o != 32'h0)) bad++;
      if (busy_o) act_q.push_back(mk(we_o ? 2 : (re_o ? 1 : 0), addr_o, data_csr_o));
      if (done_o) begin
        lat = k + 2;
        p = pass_o; t = timeout_o; s = signature_o;
        break;
      end
      if (k == 0) begin
        start_i = 1'b0; coeff_i = ~coeff; golden_i = ~golden; num_cycles_i = 16'(n + 7);
      end
      if (pulse_mid && k == 6) begin
        start_i = 1'b1; coeff_i = 32'h1111_1111; golden_i = 32'h2222_2222; num_cycles_i = 16'd3;
      end
      if (pulse_mid && k == 7) start_i = 1'b0;
    end
    start_i = 1'b0;

    check({tag, " latency"}, 64'(lat), 64'(exp_q.size() + 1));
    check({tag, " trace_len"}, 64'(act_q.size()), 64'(exp_q.size()));
    first_bad = -1;
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++) begin
      if (act_q[i].kind != exp_q[i].kind || act_q[i].addr != exp_q[i].addr ||
          (exp_q[i].kind != 1 && act_q[i].data != exp_q[i].data)) begin
        first_bad = i;
        break;
      end
    end
    checks++;
    if (first_bad >= 0) begin
      errors++;
      $display("FAIL %s trace[%0d]: got kind=%0d addr=%0h data=%0h expected kind=%0d addr=%0h data=%0h",
               tag, first_bad, act_q[first_bad].kind, act_q[first_bad].addr, act_q[first_bad].data,
               exp_q[first_bad].kind, exp_q[first_bad].addr, exp_q[first_bad].data);
    end
    check({tag, " bus_rules"}, 64'(bad), 64'h0);
    check({tag, " signature"}, 64'(s), to ? 64'h0 : 64'(ref_sig));
    check({tag, " pass"}, 64'(p), 64'(exp_pass));
    check({tag, " timeout"}, 64'(t), 64'(to));
    @(negedge clk_i);
    check({tag, " done_pulse"}, {62'h0, done_o, busy_o}, 64'h0);
    check({tag, " pass_held"}, 64'(pass_o), 64'(exp_pass));
  endtask

  typedef struct {
    logic [31:0] coeff; int n; int fn; logic [31:0] gxor; bit pulse;
    bit exp_pass; bit exp_to; int exp_lat;
  } vec_t;
  vec_t tbl[6];

  initial begin
    bit p, t;
    int lat;
    logic [31:0] c, g;
    int n, fn;

    tbl[0] = '{32'h8000_0057,  4,  0, 32'h0, 1'b0, 1'b1, 1'b0, 13};
    tbl[1] = '{32'h8000_0057,  4,  0, 32'h1, 1'b0, 1'b0, 1'b0, 13};
    tbl[2] = '{32'h8000_0057,  0,  0, 32'h0, 1'b0, 1'b1, 1'b0,  9};
    tbl[3] = '{32'h04C1_1DB7,  2, 99, 32'h0, 1'b0, 1'b0, 1'b1, 13};
    tbl[4] = '{32'h1234_5679, 20,  3, 32'h0, 1'b1, 1'b1, 1'b0, 32};
    tbl[5] = '{32'hDEAD_BEEF,  1,  3, 32'h0, 1'b0, 1'b1, 1'b0, 13};

    rst_i = 1'b1; start_i = 1'b0; coeff_i = '0; golden_i = '0; num_cycles_i = '0;
    #1;
    check("reset_ctrl", {58'h0, re_o, we_o, busy_o, done_o, pass_o, timeout_o}, 64'h0);
    check("reset_bus", addr_o | 64'(data_csr_o) | 64'(signature_o), 64'h0);
    @(negedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      g = misr_ref(tbl[i].coeff, tbl[i].n + 1) ^ tbl[i].gxor;
      run_one($sformatf("vec%0d", i), tbl[i].coeff, g, tbl[i].n, tbl[i].fn, tbl[i].pulse, p, t, lat);
      check($sformatf("vec%0d tbl_pass", i), 64'(p), 64'(tbl[i].exp_pass));
      check($sformatf("vec%0d tbl_timeout", i), 64'(t), 64'(tbl[i].exp_to));
      check($sformatf("vec%0d tbl_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
    end

    // Mid-run reset at N = 100
    fail_n = 0;
    coeff_i = 32'hA5A5_0001; golden_i = 32'h0; num_cycles_i = 16'd100; start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge clk_i);
    check("midrun_busy", 64'(busy_o), 64'h1);
    #2 rst_i = 1'b1;
    #1;
    check("midrun_rst_ctrl", {58'h0, re_o, we_o, busy_o, done_o, pass_o, timeout_o}, 64'h0);
    check("midrun_rst_bus", addr_o | 64'(data_csr_o) | 64'(signature_o), 64'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("midrun_quiet", {61'h0, re_o, we_o, busy_o}, 64'h0);
    end
    rst_i = 1'b0;
    run_one("after_rst", 32'h8000_0057, misr_ref(32'h8000_0057, 5), 4, 0, 1'b0, p, t, lat);

    // start_i held high relaunches right after FINISH
    fail_n = 0;
    coeff_i = 32'h0BAD_F00D; golden_i = misr_ref(32'h0BAD_F00D, 2); num_cycles_i = 16'd1;
    start_i = 1'b1;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (done_o) begin lat = k; break; end
    end
    check("relaunch_first_done", 64'(lat >= 0), 64'h1);
    @(negedge clk_i);
    check("relaunch_idle_gap", 64'(busy_o), 64'h0);
    @(negedge clk_i);
    check("relaunch_coeff_wr", {we_o, re_o, addr_o, data_csr_o} == {1'b1, 1'b0, A_COEFF, 32'h0BAD_F00D}, 1);
    start_i = 1'b0;
    lat = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i);
      if (done_o) begin lat = k; break; end
    end
    check("relaunch_second_done", 64'(lat >= 0), 64'h1);
    check("relaunch_second_pass", 64'(pass_o), 64'h1);
    @(negedge clk_i);

    // Randomised runs against the model
    for (int r = 0; r < 10; r++) begin
      c  = $urandom;
      n  = $urandom_range(0, 12);
      fn = $urandom_range(0, 5);
      g  = misr_ref(c, n + 1);
      if ($urandom_range(0, 1) == 1) g = g ^ (32'h1 << $urandom_range(0, 31));
      run_one($sformatf("rnd%0d", r), c, g, n, fn, 1'b0, p, t, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
